// File: rtl/decoder_pipe.sv
// Registered RV32I ID-stage decoder: valid/ready handshake toward IF and EX,
// load-use bubble insertion, flush, illegal-opcode flagging and saturating event counters.
module decoder_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  input  logic             ex_ready_i,
  output logic             ex_valid_o,
  output logic [XLEN-1:0]  pc_o,
  output logic             alu_src_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             branch_o,
  output logic [1:0]       alu_op_o,
  output logic [1:0]       jump_o,
  output logic [1:0]       alu_a_sel_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [4:0]       rd_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic            alu_src;
    logic            mem_to_reg;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic [1:0]      alu_op;
    logic [1:0]      jump;
    logic [1:0]      alu_a_sel;
    logic            illegal;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } bundle_t;

  bundle_t          dec_s;
  bundle_t          out_r;
  logic             valid_r;
  logic [31:0]      imm32_s;
  logic             uses_rs1_s;
  logic             uses_rs2_s;
  logic             load_use_s;
  logic             in_ready_s;
  logic             xfer_s;
  logic [CNT_W-1:0] illegal_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    else return v + CNT_W'(1'b1);
  endfunction

  // Opcode decode into the control bundle, immediate and register-use flags.
  always_comb begin
    dec_s      = '0;
    imm32_s    = 32'd0;
    uses_rs1_s = 1'b0;
    uses_rs2_s = 1'b0;
    dec_s.pc   = pc_i;
    dec_s.rs1  = instr_i[19:15];
    dec_s.rs2  = instr_i[24:20];
    dec_s.rd   = instr_i[11:7];
    case (instr_i[6:0])
      OP_R: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_op    = 2'b10;
        uses_rs1_s      = 1'b1;
        uses_rs2_s      = 1'b1;
      end
      OP_LOAD: begin
        dec_s.alu_src    = 1'b1;
        dec_s.mem_to_reg = 1'b1;
        dec_s.reg_write  = 1'b1;
        dec_s.mem_read   = 1'b1;
        uses_rs1_s       = 1'b1;
        imm32_s          = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OP_STORE: begin
        dec_s.alu_src   = 1'b1;
        dec_s.mem_write = 1'b1;
        uses_rs1_s      = 1'b1;
        uses_rs2_s      = 1'b1;
        imm32_s         = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OP_BRANCH: begin
        dec_s.branch = 1'b1;
        dec_s.alu_op = 2'b01;
        uses_rs1_s   = 1'b1;
        uses_rs2_s   = 1'b1;
        imm32_s      = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      end
      OP_IMM: begin
        dec_s.alu_src   = 1'b1;
        dec_s.reg_write = 1'b1;
        dec_s.alu_op    = 2'b11;
        uses_rs1_s      = 1'b1;
        imm32_s         = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OP_JAL: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_op    = 2'b11;
        dec_s.jump      = 2'b01;
        imm32_s         = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                           instr_i[30:21], 1'b0};
      end
      OP_JALR: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_op    = 2'b11;
        dec_s.jump      = 2'b10;
        uses_rs1_s      = 1'b1;
        imm32_s         = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OP_LUI: begin
        dec_s.alu_src   = 1'b1;
        dec_s.reg_write = 1'b1;
        dec_s.alu_a_sel = 2'b10;
        imm32_s         = {instr_i[31:12], 12'd0};
      end
      OP_AUIPC: begin
        dec_s.alu_src   = 1'b1;
        dec_s.reg_write = 1'b1;
        dec_s.alu_a_sel = 2'b01;
        imm32_s         = {instr_i[31:12], 12'd0};
      end
      default: dec_s.illegal = 1'b1;
    endcase
    dec_s.imm = XLEN'($signed(imm32_s));
  end

  // A load still sitting in the output register cannot forward to a dependent consumer.
  assign load_use_s = valid_r & out_r.mem_read & (out_r.rd != 5'd0) & in_valid_i &
                      ((uses_rs1_s & (dec_s.rs1 == out_r.rd)) |
                       (uses_rs2_s & (dec_s.rs2 == out_r.rd)));
  assign in_ready_s = ~flush_i & ~load_use_s & (~valid_r | ex_ready_i);
  assign xfer_s     = in_valid_i & in_ready_s;

  // Output register: flush, then load, then bubble on consume, else hold.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_r <= 1'b0;
      out_r   <= '0;
    end else if (flush_i) begin
      valid_r <= 1'b0;
    end else if (xfer_s) begin
      valid_r <= 1'b1;
      out_r   <= dec_s;
    end else if (ex_ready_i) begin
      valid_r <= 1'b0;
    end
  end

  // Saturating event counters; a flush does not clear them.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      illegal_cnt_r <= '0;
      stall_cnt_r   <= '0;
    end else begin
      if (xfer_s & dec_s.illegal) illegal_cnt_r <= sat_inc(illegal_cnt_r);
      if (load_use_s & ex_ready_i & ~flush_i) stall_cnt_r <= sat_inc(stall_cnt_r);
    end
  end

  assign in_ready_o    = in_ready_s;
  assign ex_valid_o    = valid_r;
  assign pc_o          = out_r.pc;
  assign alu_src_o     = out_r.alu_src;
  assign mem_to_reg_o  = out_r.mem_to_reg;
  assign reg_write_o   = out_r.reg_write;
  assign mem_read_o    = out_r.mem_read;
  assign mem_write_o   = out_r.mem_write;
  assign branch_o      = out_r.branch;
  assign alu_op_o      = out_r.alu_op;
  assign jump_o        = out_r.jump;
  assign alu_a_sel_o   = out_r.alu_a_sel;
  assign imm_o         = out_r.imm;
  assign rs1_o         = out_r.rs1;
  assign rs2_o         = out_r.rs2;
  assign rd_o          = out_r.rd;
  assign illegal_o     = out_r.illegal;
  assign illegal_cnt_o = illegal_cnt_r;
  assign stall_cnt_o   = stall_cnt_r;

endmodule

// File: tb/tb_decoder_pipe.sv
// Randomized scoreboard bench for decoder_pipe: a spec-level reference model predicts
// in_ready_o, counters and the output bundle; a monitor compares what EX sees.
module tb_decoder_pipe;

  localparam int XLEN  = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             in_valid_i;
  logic [31:0]      instr_i;
  logic [XLEN-1:0]  pc_i;
  logic             in_ready_o;
  logic             flush_i;
  logic             ex_ready_i;
  logic             ex_valid_o;
  logic [XLEN-1:0]  pc_o;
  logic             alu_src_o, mem_to_reg_o, reg_write_o, mem_read_o, mem_write_o, branch_o;
  logic [1:0]       alu_op_o, jump_o, alu_a_sel_o;
  logic [XLEN-1:0]  imm_o;
  logic [4:0]       rs1_o, rs2_o, rd_o;
  logic             illegal_o;
  logic [CNT_W-1:0] illegal_cnt_o, stall_cnt_o;

  always #5 clk = ~clk;

  decoder_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .instr_i(instr_i), .pc_i(pc_i),
    .in_ready_o(in_ready_o), .flush_i(flush_i), .ex_ready_i(ex_ready_i),
    .ex_valid_o(ex_valid_o), .pc_o(pc_o), .alu_src_o(alu_src_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .branch_o(branch_o), .alu_op_o(alu_op_o),
    .jump_o(jump_o), .alu_a_sel_o(alu_a_sel_o), .imm_o(imm_o), .rs1_o(rs1_o),
    .rs2_o(rs2_o), .rd_o(rd_o), .illegal_o(illegal_o),
    .illegal_cnt_o(illegal_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  // ctl = {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch}
  typedef struct packed {
    logic [5:0]  ctl;
    logic [1:0]  alu_op;
    logic [1:0]  jump;
    logic [1:0]  asel;
    logic        illegal;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mdl_valid;
  exp_t mdl_cur;
  int   mdl_ill;
  int   mdl_stall;
  logic acc;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t        e;
    logic [31:0] sx;
    e     = '0;
    e.pc  = pc;
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    sx    = {32{w[31]}};
    case (w[6:0])
      7'b0110011: begin e.ctl = 6'b001000; e.alu_op = 2'b10; end
      7'b0000011: begin e.ctl = 6'b111100; e.imm = (sx << 11) | 32'(w[30:20]); end
      7'b0100011: begin
        e.ctl = 6'b100010;
        e.imm = (sx << 11) | (32'(w[30:25]) << 5) | 32'(w[11:7]);
      end
      7'b1100011: begin
        e.ctl = 6'b000001; e.alu_op = 2'b01;
        e.imm = (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      end
      7'b0010011: begin e.ctl = 6'b101000; e.alu_op = 2'b11; e.imm = (sx << 11) | 32'(w[30:20]); end
      7'b1101111: begin
        e.ctl = 6'b001000; e.alu_op = 2'b11; e.jump = 2'b01;
        e.imm = (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      end
      7'b1100111: begin
        e.ctl = 6'b001000; e.alu_op = 2'b11; e.jump = 2'b10;
        e.imm = (sx << 11) | 32'(w[30:20]);
      end
      7'b0110111: begin e.ctl = 6'b101000; e.asel = 2'b10; e.imm = 32'(w[31:12]) << 12; end
      7'b0010111: begin e.ctl = 6'b101000; e.asel = 2'b01; e.imm = 32'(w[31:12]) << 12; end
      default:    e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  // {uses_rs2, uses_rs1}
  function automatic logic [1:0] ref_uses(input logic [31:0] w);
    case (w[6:0])
      7'b0110011, 7'b0100011, 7'b1100011: return 2'b11;
      7'b0000011, 7'b0010011, 7'b1100111: return 2'b01;
      default:                            return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9] = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011,
                              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) w[6:0] = ops[k];
    else if (k == 9) w[1:0] = 2'b00;
    else w[6:0] = 7'b1110011;
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  // One cycle: drive inputs, check in_ready_o and counters, advance the model.
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                      input logic er, input logic fl, output logic accepted);
    exp_t       e;
    logic [1:0] u;
    bit         lu, rdy;
    @(negedge clk);
    in_valid_i = v; instr_i = w; pc_i = pc; ex_ready_i = er; flush_i = fl;
    #4;
    e   = ref_decode(w, pc);
    u   = ref_uses(w);
    lu  = mdl_valid && mdl_cur.ctl[2] && (mdl_cur.rd != 5'd0) && v &&
          ((u[0] && e.rs1 == mdl_cur.rd) || (u[1] && e.rs2 == mdl_cur.rd));
    rdy = !fl && !lu && (!mdl_valid || er);
    chk("in_ready", 128'(in_ready_o), 128'(rdy));
    chk("illegal_cnt", 128'(illegal_cnt_o), 128'(mdl_ill));
    chk("stall_cnt", 128'(stall_cnt_o), 128'(mdl_stall));
    accepted = v && rdy;
    if (accepted && e.illegal && mdl_ill < 255) mdl_ill++;
    if (lu && er && !fl && mdl_stall < 255) mdl_stall++;
    if (fl) mdl_valid = 1'b0;
    else if (accepted) begin
      mdl_valid = 1'b1;
      mdl_cur   = e;
      q.push_back(e);
    end else if (er) mdl_valid = 1'b0;
  endtask

  // Monitor: whatever the output register presents must match the scoreboard head.
  always @(negedge clk) begin
    exp_t g;
    #3;
    if (rst_i) begin
      if (ex_valid_o) begin
        g = {alu_src_o, mem_to_reg_o, reg_write_o, mem_read_o, mem_write_o, branch_o,
             alu_op_o, jump_o, alu_a_sel_o, illegal_o, imm_o, pc_o, rs1_o, rs2_o, rd_o};
        if (q.size() == 0) chk("unexpected_valid", 128'(1), 128'(0));
        else begin
          chk("payload", 128'(g), 128'(q[0]));
          if (ex_ready_i || flush_i) void'(q.pop_front());
        end
      end else if (q.size() != 0) begin
        chk("missing_valid", 128'(0), 128'(1));
        q.delete();
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pend_w;
    bit          pend;
    int          tries;
    rst_i = 1'b0; in_valid_i = 1'b0; instr_i = 32'd0; pc_i = 32'd0;
    flush_i = 1'b0; ex_ready_i = 1'b0;
    mdl_valid = 1'b0; mdl_cur = '0; mdl_ill = 0; mdl_stall = 0;
    #12;
    chk("reset_state", {ex_valid_o, alu_src_o, mem_to_reg_o, reg_write_o, mem_read_o,
        mem_write_o, branch_o, alu_op_o, jump_o, alu_a_sel_o, imm_o, pc_o, rs1_o, rs2_o,
        rd_o, illegal_o, illegal_cnt_o, stall_cnt_o}, 128'(0));
    @(negedge clk); rst_i = 1'b1; #1;
    chk("ready_after_reset", 128'(in_ready_o), 128'(1));

    // add x3,x1,x2
    step(1'b1, 32'h002081B3, 32'h100, 1'b1, 1'b0, acc);
    @(posedge clk); #1;
    chk("add_valid", 128'(ex_valid_o), 128'(1));
    chk("add_fields", {reg_write_o, alu_op_o, rd_o, rs1_o, rs2_o, imm_o},
        {1'b1, 2'b10, 5'd3, 5'd1, 5'd2, 32'd0});

    // lw x5,0(x1) then dependent add x6,x5,x1
    step(1'b1, 32'h0000A283, 32'h104, 1'b1, 1'b0, acc);
    step(1'b1, 32'h00128333, 32'h108, 1'b1, 1'b0, acc);
    chk("lu_not_accepted", 128'(acc), 128'(0));
    @(posedge clk); #1;
    chk("lu_bubble", 128'(ex_valid_o), 128'(0));
    step(1'b1, 32'h00128333, 32'h108, 1'b1, 1'b0, acc);
    chk("lu_retry_accepted", 128'(acc), 128'(1));
    @(posedge clk); #1;
    chk("lu_stall_cnt", 128'(stall_cnt_o), 128'(1));

    // beq x0,x0,-4 then lui x7,0x12345
    step(1'b1, 32'hFE000EE3, 32'h10C, 1'b1, 1'b0, acc);
    @(posedge clk); #1;
    chk("beq_fields", {branch_o, alu_op_o, imm_o}, {1'b1, 2'b01, 32'hFFFFFFFC});
    step(1'b1, 32'h123453B7, 32'h110, 1'b1, 1'b0, acc);
    @(posedge clk); #1;
    chk("lui_fields", {imm_o, alu_a_sel_o, rd_o}, {32'h12345000, 2'b10, 5'd7});
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, acc);

    // illegal word, then saturate the counter
    step(1'b1, 32'hFFFFFFFF, 32'h200, 1'b1, 1'b0, acc);
    @(posedge clk); #1;
    chk("illegal_first", {illegal_o, alu_src_o, mem_to_reg_o, reg_write_o, mem_read_o,
        mem_write_o, branch_o, alu_op_o, jump_o, illegal_cnt_o},
        {1'b1, 6'b000000, 2'b00, 2'b00, 8'd1});
    for (int i = 0; i < 299; i++) step(1'b1, 32'hFFFFFFFF, 32'h204, 1'b1, 1'b0, acc);
    @(posedge clk); #1;
    chk("illegal_saturated", 128'(illegal_cnt_o), 128'(255));
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, acc);

    // backpressure: hold 5 cycles, then flush with a pending IF instruction
    step(1'b1, 32'h002081B3, 32'h300, 1'b1, 1'b0, acc);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h00A00513, 32'h304, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00A00513, 32'h304, 1'b0, 1'b1, acc);
    chk("flush_drops_input", 128'(acc), 128'(0));
    @(posedge clk); #1;
    chk("flush_clears_valid", 128'(ex_valid_o), 128'(0));
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, acc);

    // asynchronous reset while the output register is occupied
    step(1'b1, 32'h00A00513, 32'h400, 1'b1, 1'b0, acc);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, acc);
    @(negedge clk); #2;
    rst_i = 1'b0; #1;
    chk("async_reset", {ex_valid_o, alu_src_o, mem_to_reg_o, reg_write_o, mem_read_o,
        mem_write_o, branch_o, alu_op_o, jump_o, alu_a_sel_o, imm_o, pc_o, rs1_o, rs2_o,
        rd_o, illegal_o, illegal_cnt_o, stall_cnt_o}, 128'(0));
    q.delete(); mdl_valid = 1'b0; mdl_ill = 0; mdl_stall = 0;
    @(negedge clk); rst_i = 1'b1;

    // randomized traffic; IF holds an unaccepted instruction unless flushed
    pend = 1'b0; pend_w = 32'd0; tries = 0;
    for (int i = 0; i < 2000; i++) begin
      logic v, er, fl;
      if (!pend) begin
        pend_w = rand_instr();
        pend   = ($urandom_range(0, 9) < 8);
      end
      v  = pend;
      er = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 19) == 0);
      step(v, pend_w, 32'(i * 4), er, fl, acc);
      if (acc || fl) pend = 1'b0;
    end

    // drain with a bounded wait
    while (q.size() != 0 && tries < 20) begin
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, acc);
      tries++;
    end
    @(posedge clk); #1;
    chk("drained", 128'(q.size()), 128'(0));
    chk("final_valid", 128'(ex_valid_o), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
